mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported `memory_interface` between the instruction-fetch port and the load/store port of the core. It accepts one access at a time, chooses between ports round-robin, and issues a one-cycle `request` pulse to memory. It waits for `valid`, then returns read data or a store acknowledge to the owning port. A watchdog ends any access that never completes.

---
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the fetch (i_*) and
// load/store (d_*) ports; one access in flight at a time, guarded by a watchdog.
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_request,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic       OWN_I       = 1'b0;
  localparam logic       OWN_D       = 1'b1;
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_last;
  logic                  r_owner;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [7:0]            r_cnt;
  logic                  r_err;
  logic [7:0]            w_cnt_inc;
  logic                  w_grant_i;
  logic                  w_grant_d;
  logic                  w_timeout;
  logic [DATA_WIDTH-1:0] w_rdata  [2];
  logic                  w_rvalid [2];

  assign w_cnt_inc = r_cnt + 8'd1;

  always_comb begin
    w_state_next = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!rst) begin
          // On a tie the port that was not served last wins.
          if (i_req && d_req) begin
            if (r_last == OWN_D) w_grant_i = 1'b1;
            else                 w_grant_d = 1'b1;
          end else if (i_req) begin
            w_grant_i = 1'b1;
          end else if (d_req) begin
            w_grant_d = 1'b1;
          end
          if (w_grant_i || w_grant_d) w_state_next = ISSUE;
        end
      end
      ISSUE: w_state_next = WAIT;
      WAIT: begin
        if (mem_valid) begin
          w_state_next = RESP;
        end else if (w_cnt_inc == TIMEOUT_CNT) begin
          w_timeout    = 1'b1;
          w_state_next = RESP;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= OWN_D;
      r_owner <= OWN_I;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (w_grant_i) begin
            r_owner <= OWN_I;
            r_last  <= OWN_I;
            r_we    <= 1'b0;
            r_addr  <= i_addr;
            r_wdata <= '0;
            r_err   <= 1'b0;
          end else if (w_grant_d) begin
            r_owner <= OWN_D;
            r_last  <= OWN_D;
            r_we    <= d_we;
            r_addr  <= d_addr;
            r_wdata <= d_wdata;
            r_err   <= 1'b0;
          end
        end
        ISSUE: r_cnt <= '0;
        WAIT: begin
          if (!mem_valid) begin
            r_cnt <= w_cnt_inc;
            if (w_timeout) r_err <= 1'b1;
          end
        end
        RESP:    r_err <= 1'b0;
        default: ;
      endcase
    end
  end

  // Per-port read-data holding register and response strobe.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_rdata <= '0;
      end else if (r_state == WAIT && r_owner == 1'(gi)) begin
        if (mem_valid)      r_rdata <= r_we ? '0 : mem_rdata;
        else if (w_timeout) r_rdata <= '0;
      end
    end

    assign w_rdata[gi]  = r_rdata;
    assign w_rvalid[gi] = (r_state == RESP) && (r_owner == 1'(gi));
  end

  assign i_gnt       = w_grant_i;
  assign d_gnt       = w_grant_d;
  assign i_rvalid    = w_rvalid[0];
  assign d_rvalid    = w_rvalid[1];
  assign i_rdata     = w_rdata[0];
  assign d_rdata     = w_rdata[1];
  assign mem_request = (r_state == ISSUE);
  assign mem_we      = r_we & mem_request;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign err         = (r_state == RESP) && r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: small word memory model, fixed-latency checks per step.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_request;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  // Memory model: answers a request one cycle later when enabled.
  logic [31:0] mem_arr [0:63] = '{default: 32'h0};
  logic        mem_en   = 1'b1;
  logic        mv_model = 1'b0;
  logic [31:0] md_model = 32'h0;
  logic        mv_force = 1'b0;
  logic [31:0] md_force = 32'h0;
  int          req_count = 0;

  assign mem_valid = mv_model | mv_force;
  assign mem_rdata = mv_force ? md_force : md_model;

  always @(posedge clk) begin
    mv_model <= 1'b0;
    if (rst) mem_arr[4] <= 32'h00500093;
    if (mem_request) begin
      req_count <= req_count + 1;
      if (mem_en) begin
        mv_model <= 1'b1;
        if (mem_we) mem_arr[mem_addr[7:2]] <= mem_wdata;
        else        md_model <= mem_arr[mem_addr[7:2]];
      end
    end
  end

  mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(3)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_request(mem_request), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full best-case access, starting at a negedge with the arbiter idle.
  task automatic access(input logic is_d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input string tag);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    #1;
    check({tag, ".gnt"},   is_d ? d_gnt : i_gnt, 1);
    check({tag, ".gnt_o"}, is_d ? i_gnt : d_gnt, 0);
    cyc();
    if (is_d) d_req = 1'b0; else i_req = 1'b0;
    check({tag, ".req"},  mem_request, 1);
    check({tag, ".we"},   mem_we, we);
    check({tag, ".addr"}, mem_addr, addr);
    if (we) check({tag, ".wdata"}, mem_wdata, wdata);
    cyc();
    check({tag, ".req_off"}, mem_request, 0);
    cyc();
    check({tag, ".rvalid"},   is_d ? d_rvalid : i_rvalid, 1);
    check({tag, ".rvalid_o"}, is_d ? i_rvalid : d_rvalid, 0);
    check({tag, ".rdata"},    is_d ? d_rdata : i_rdata, exp_rd);
    check({tag, ".err"},      err, 0);
    cyc();
    check({tag, ".rvalid_end"}, is_d ? d_rvalid : i_rvalid, 0);
    $display("access %s: port=%s we=%0b addr=%h", tag, is_d ? "D" : "I", we, addr);
  endtask

  logic        exp_i [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  int          base;

  initial begin
    rst = 1'b1; i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    @(posedge clk); cyc();

    // Reset state, grant suppressed while reset is high.
    check("rst.i_gnt", i_gnt, 0);
    check("rst.mem_request", mem_request, 0);
    check("rst.mem_we", mem_we, 0);
    check("rst.mem_addr", mem_addr, 0);
    check("rst.i_rdata", i_rdata, 0);
    check("rst.d_rdata", d_rdata, 0);
    check("rst.err", err, 0);
    i_req = 1'b0;
    rst   = 1'b0;

    // Fetch only, then store/load at the same address.
    access(1'b0, 1'b0, 32'h10, 32'h0, 32'h00500093, "fetch");
    access(1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 32'h0, "store");
    check("store.i_rdata_hold", i_rdata, 32'h00500093);
    access(1'b1, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, "load");

    // Both ports requesting continuously from a fresh reset: I, D, I, D.
    rst = 1'b1; cyc(); rst = 1'b0;
    i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("tie%0d.i_gnt", k), i_gnt, exp_i[k]);
      check($sformatf("tie%0d.d_gnt", k), d_gnt, !exp_i[k]);
      cyc();
      check($sformatf("tie%0d.no_gnt", k), i_gnt | d_gnt, 0);
      check($sformatf("tie%0d.addr", k), mem_addr, exp_i[k] ? 32'h10 : 32'h40);
      cyc();
      cyc();
      check($sformatf("tie%0d.i_rvalid", k), i_rvalid, exp_i[k]);
      check($sformatf("tie%0d.d_rvalid", k), d_rvalid, !exp_i[k]);
      check($sformatf("tie%0d.rdata", k), exp_i[k] ? i_rdata : d_rdata,
            exp_i[k] ? 32'h00500093 : 32'hCAFEF00D);
      cyc();
      $display("access tie%0d: port=%s", k, exp_i[k] ? "I" : "D");
    end
    i_req = 1'b0; d_req = 1'b0;

    // Watchdog: memory never answers, TIMEOUT=3.
    mem_en = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    #1;
    check("to.gnt", d_gnt, 1);
    cyc();
    d_req = 1'b0;
    check("to.req", mem_request, 1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check($sformatf("to.wait%0d", k), d_rvalid | err, 0);
    end
    cyc();
    check("to.err", err, 1);
    check("to.d_rvalid", d_rvalid, 1);
    check("to.d_rdata", d_rdata, 0);
    check("to.i_rvalid", i_rvalid, 0);
    cyc();
    check("to.err_end", err, 0);
    mv_force = 1'b1; md_force = 32'h12345678;
    cyc();
    mv_force = 1'b0;
    check("late.rvalid", i_rvalid | d_rvalid, 0);
    check("late.req", mem_request, 0);
    cyc();
    check("late.rvalid2", i_rvalid | d_rvalid, 0);
    check("late.d_rdata", d_rdata, 0);
    check("late.i_rdata", i_rdata, 32'h00500093);
    mem_en = 1'b1;
    $display("access timeout: port=D addr=00000080 aborted");

    // Reset during WAIT of a fetch access.
    i_req = 1'b1; i_addr = 32'h10;
    #1;
    check("rw.gnt", i_gnt, 1);
    cyc();
    i_req = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    check("rw.i_rvalid", i_rvalid, 0);
    check("rw.mem_request", mem_request, 0);
    check("rw.mem_we", mem_we, 0);
    check("rw.mem_addr", mem_addr, 0);
    check("rw.mem_wdata", mem_wdata, 0);
    check("rw.i_rdata", i_rdata, 0);
    check("rw.err", err, 0);
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    #1;
    check("rw.gnt_in_rst", i_gnt | d_gnt, 0);
    cyc();
    rst = 1'b0;
    #1;
    check("rw.tie_i", i_gnt, 1);
    check("rw.tie_d", d_gnt, 0);
    cyc();
    i_req = 1'b0; d_req = 1'b0;
    cyc(); cyc();
    check("rw.i_rvalid_after", i_rvalid, 1);
    check("rw.i_rdata_after", i_rdata, 32'h00500093);
    check("rw.d_rvalid_after", d_rvalid, 0);
    cyc();
    $display("access reset_wait: port=I addr=00000010");

    // d_req raised and dropped while busy: never granted, never issued.
    base = req_count;
    i_req = 1'b1; i_addr = 32'h10;
    #1;
    check("drop.i_gnt", i_gnt, 1);
    cyc();
    i_req = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
    #1;
    check("drop.d_gnt", d_gnt, 0);
    cyc();
    d_req = 1'b0;
    cyc();
    check("drop.i_rvalid", i_rvalid, 1);
    for (int k = 0; k < 6; k++) begin
      cyc();
      check($sformatf("drop.idle%0d", k), mem_request | d_gnt, 0);
    end
    check("drop.req_count", req_count - base, 1);
    $display("access drop: port=I only");
    access(1'b1, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, "reload");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
